// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the ID/EX/WB hazard controller.
//   state_t    - controller state (RUN, STALL, FLUSH, HALT)
//   FWD_*      - forwarding-mux select encodings for the ALU operands
//   sb_entry_t - scoreboard entry describing one in-flight RF writer
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_EX = 2'b01;
  localparam logic [1:0] FWD_WB = 2'b10;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
  } sb_entry_t;

endpackage

// File: rtl/hazard_src_cmp.sv
// hazard_src_cmp: compares one ID source operand against the EX and WB
// scoreboard entries.
// Ports:
//   use_src  - the ID instruction actually reads this source
//   rs       - source register address
//   ex_entry - scoreboard entry of the instruction in EX
//   wb_valid - WB holds a valid RF writer
//   wb_rd    - destination register of the WB writer
//   match_ex - youngest writer (EX) produces this source
//   match_wb - WB writer produces this source
//   load_use - EX writer is a load whose data is not yet available
//   fwd      - operand select assuming forwarding is allowed
module hazard_src_cmp
  import pipe_ctrl_pkg::*;
(
  input  logic       use_src,
  input  logic [4:0] rs,
  input  sb_entry_t  ex_entry,
  input  logic       wb_valid,
  input  logic [4:0] wb_rd,
  output logic       match_ex,
  output logic       match_wb,
  output logic       load_use,
  output logic [1:0] fwd
);

  // x0 is hard-wired zero, so a writer of x0 never supplies a value.
  assign match_ex = use_src && ex_entry.valid && (ex_entry.rd != 5'd0) && (ex_entry.rd == rs);
  assign match_wb = use_src && wb_valid && (wb_rd != 5'd0) && (wb_rd == rs);
  assign load_use = match_ex && ex_entry.is_load;

  // EX is the youngest writer, so it wins over WB.
  always_comb begin
    fwd = FWD_RF;
    if (match_ex) begin
      fwd = FWD_EX;
    end else if (match_wb) begin
      fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and sequencing controller for the 3-stage
// ID/EX/WB integer pipeline. Tracks EX/WB destination registers and drives
// stall, bubble, flush, forwarding selects, a sticky halt and two saturating
// performance counters. Contains no datapath.
// Build option: define PIPE_HAZARD_FWD_EN to enable operand forwarding (only
// load-use then stalls); otherwise any EX/WB match stalls and fwd selects
// stay at RF.
// Parameters: FLUSH_CYCLES (1..3) cycles ID is flushed after a redirect,
//             CNT_W width of the saturating counters.
// Ports:
//   clk, rst_n                      - clock, async active-low reset
//   id_valid, id_rs1/2, id_use_rs1/2,
//   id_rd, id_wr_en, id_is_load     - decoded instruction in ID
//   ex_redirect                     - taken branch / jump resolved in EX
//   ex_tohost_we, ex_tohost_data    - tohost CSR write in EX
//   pipe_en_id                      - PC and ID registers advance
//   bubble_ex                       - load a NOP into EX at the next edge
//   flush_id                        - kill the wrong-path ID instruction
//   fwd_sel_a/b                     - ALU operand source select
//   halt                            - sticky program-complete flag
//   stall_cnt, flush_cnt            - stalled / flushing cycle counters
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_wr_en,
  input  logic             id_is_load,
  input  logic             ex_redirect,
  input  logic             ex_tohost_we,
  input  logic [31:0]      ex_tohost_data,
  output logic             pipe_en_id,
  output logic             bubble_ex,
  output logic             flush_id,
  output logic [1:0]       fwd_sel_a,
  output logic [1:0]       fwd_sel_b,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

`ifdef PIPE_HAZARD_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  localparam logic [1:0] FLUSH_EXTRA = 2'(FLUSH_CYCLES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  state_t     state;
  logic [1:0] flush_left;

  logic       ex_vld_p1;
  logic [4:0] ex_rd_p1;
  logic       ex_ld_p1;
  logic       wb_vld_p2;
  logic [4:0] wb_rd_p2;
  sb_entry_t  sb_ex;

  logic       m_ex_a, m_wb_a, lu_a;
  logic       m_ex_b, m_wb_b, lu_b;
  logic [1:0] fwd_a_raw, fwd_b_raw;
  logic       hazard, in_flow, take_redirect, do_stall, tohost_hit;

  assign sb_ex = '{valid: ex_vld_p1, rd: ex_rd_p1, is_load: ex_ld_p1};

  hazard_src_cmp u_cmp_a (
    .use_src  (id_use_rs1),
    .rs       (id_rs1),
    .ex_entry (sb_ex),
    .wb_valid (wb_vld_p2),
    .wb_rd    (wb_rd_p2),
    .match_ex (m_ex_a),
    .match_wb (m_wb_a),
    .load_use (lu_a),
    .fwd      (fwd_a_raw)
  );

  hazard_src_cmp u_cmp_b (
    .use_src  (id_use_rs2),
    .rs       (id_rs2),
    .ex_entry (sb_ex),
    .wb_valid (wb_vld_p2),
    .wb_rd    (wb_rd_p2),
    .match_ex (m_ex_b),
    .match_wb (m_wb_b),
    .load_use (lu_b),
    .fwd      (fwd_b_raw)
  );

  // Without forwarding the consumer must wait until the writer has left WB.
  assign hazard        = FWD_EN ? (lu_a | lu_b) : (m_ex_a | m_wb_a | m_ex_b | m_wb_b);
  assign in_flow       = (state == RUN) || (state == STALL);
  assign take_redirect = in_flow && ex_redirect;
  assign do_stall      = in_flow && !ex_redirect && hazard;
  assign tohost_hit    = ex_tohost_we && (ex_tohost_data != 32'd0);

  // Outputs are combinational so hazards act in the same cycle; reset forces
  // the pipe to hold with a bubble regardless of state.
  always_comb begin
    pipe_en_id = 1'b1;
    bubble_ex  = 1'b0;
    flush_id   = 1'b0;
    fwd_sel_a  = FWD_RF;
    fwd_sel_b  = FWD_RF;
    halt       = 1'b0;
    if (!rst_n) begin
      pipe_en_id = 1'b0;
      bubble_ex  = 1'b1;
    end else begin
      case (state)
        HALT: begin
          pipe_en_id = 1'b0;
          bubble_ex  = 1'b1;
          halt       = 1'b1;
        end
        FLUSH: begin
          bubble_ex = 1'b1;
          flush_id  = 1'b1;
        end
        default: begin
          if (take_redirect) begin
            bubble_ex = 1'b1;
            flush_id  = 1'b1;
          end else if (hazard) begin
            pipe_en_id = 1'b0;
            bubble_ex  = 1'b1;
          end else begin
            fwd_sel_a = FWD_EN ? fwd_a_raw : FWD_RF;
            fwd_sel_b = FWD_EN ? fwd_b_raw : FWD_RF;
          end
        end
      endcase
    end
  end

  // ---- ID -> EX -> WB scoreboard: valid bits and control state ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      flush_left <= 2'd0;
      ex_vld_p1  <= 1'b0;
      wb_vld_p2  <= 1'b0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      ex_vld_p1 <= id_valid && id_wr_en && !bubble_ex;
      wb_vld_p2 <= ex_vld_p1;
      if (do_stall) stall_cnt <= sat_inc(stall_cnt);
      if (flush_id) flush_cnt <= sat_inc(flush_cnt);
      if (tohost_hit) begin
        state <= HALT;
      end else begin
        case (state)
          HALT: state <= HALT;
          FLUSH: begin
            if (flush_left <= 2'd1) begin
              state      <= RUN;
              flush_left <= 2'd0;
            end else begin
              flush_left <= flush_left - 2'd1;
            end
          end
          default: begin
            if (ex_redirect) begin
              // The redirect cycle itself is the first flush cycle.
              state      <= (FLUSH_EXTRA != 2'd0) ? FLUSH : RUN;
              flush_left <= FLUSH_EXTRA;
            end else if (hazard) begin
              state <= STALL;
            end else begin
              state <= RUN;
            end
          end
        endcase
      end
    end
  end

  // ---- scoreboard register addresses (data, no reset needed) ----
  always_ff @(posedge clk) begin
    ex_rd_p1 <= id_rd;
    ex_ld_p1 <= id_is_load;
    wb_rd_p2 <= ex_rd_p1;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the 3-stage ID/EX/WB integer pipeline. It tracks the destination registers of the instructions in EX and WB and generates, every cycle:
- stall and bubble enables for the ID→EX pipeline registers;
- flush on taken branches and jumps;
- forwarding-mux selects for both ALU operands;
- a sticky halt when the test program writes a nonzero value to tohost.

It sits beside the pipeline register bank and drives its enables. It contains no datapath.

## Interface
Parameters:
- FLUSH_CYCLES, 2, number of cycles ID is flushed after a redirect (covers the PC-select delay); legal range 1–3.
- CNT_W, 16, width of the saturating performance counters.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  5  source register addresses in ID.
- id_use_rs1, id_use_rs2  in  1  the instruction in ID actually reads that source.
- id_rd  in  5  destination register in ID.
- id_wr_en  in  1  the instruction in ID writes the RF.
- id_is_load  in  1  the instruction in ID is a load (result available only in WB).
- ex_redirect  in  1  branch taken or jump resolved in EX this cycle.
- ex_tohost_we  in  1  CSR write to tohost in EX.
- ex_tohost_data  in  32  value being written to tohost.
- pipe_en_id  out  1  1 = PC and ID registers advance; 0 = hold.
- bubble_ex  out  1  1 = load a NOP into EX at the next edge.
- flush_id  out  1  1 = the ID instruction is wrong-path; kill it.
- fwd_sel_a, fwd_sel_b  out  2  operand source: 00 RF, 01 EX result, 10 WB result.
- halt  out  1  sticky program-complete flag.
- stall_cnt, flush_cnt  out  CNT_W  cycles spent stalled and flushing.

## Operation
Scoreboard:
- Two registered entries, EX and WB, each holding {valid, rd, is_load}.
- At each edge: WB ← EX, and EX ← ID info. The EX entry is written invalid if bubble_ex=1, id_valid=0, or id_wr_en=0.
- An entry with rd==0 never matches any source.

Hazard and forward logic, evaluated combinationally from the ID inputs and the scoreboard:
- Source match: use_rsN && valid && rd==rsN.
- The EX entry has priority over the WB entry (youngest writer wins).
- With forwarding enabled:
  - EX match, not a load → fwd 01.
  - EX match, load → load-use hazard; stall.
  - WB match → fwd 10.

States (pipe_ctrl_pkg::state_t): RUN, STALL, FLUSH, HALT.
- RUN or STALL:
  - A hazard holds the block in STALL: pipe_en_id=0, bubble_ex=1, fwd=00.
  - No hazard → RUN: pipe_en_id=1, bubble_ex=0.
  - A hazard is re-evaluated every cycle.
- ex_redirect in RUN or STALL:
  - Enter FLUSH at the next edge.
  - In the redirect cycle itself: flush_id=1, bubble_ex=1, pipe_en_id=1.
  - Redirect has priority over stall.
- FLUSH:
  - flush_id=1 and bubble_ex=1 for FLUSH_CYCLES−1 further cycles, tracked by an internal counter; then return to RUN.
  - A new ex_redirect cannot occur while in FLUSH, because EX holds bubbles.
- HALT:
  - Entered at the edge after ex_tohost_we=1 with ex_tohost_data≠0, from any state.
  - Halt has priority over redirect and stall.
  - Outputs: pipe_en_id=0, bubble_ex=1, flush_id=0, halt=1.
  - Counters freeze. The state is left only by reset.
- A tohost write with data==0 has no effect.

Counters:
- stall_cnt increments each cycle in STALL.
- flush_cnt increments each cycle flush_id=1.
- Both saturate at all-ones and never wrap.

## Timing
- Reset (rst_n=0, asynchronous), applied in any state including mid-FLUSH or HALT:
  - state=RUN, scoreboard invalid, counters 0;
  - pipe_en_id=0, bubble_ex=1, flush_id=0, fwd_sel_a/b=00, halt=0.
- First cycle after release: RUN, pipe_en_id=1.
- Hazard detection and forward selects: zero latency, combinational from the ID inputs in the same cycle.
- Load-use stall lasts exactly 1 cycle with forwarding enabled.
- Redirect in cycle t: flush_id is high during cycles t … t+FLUSH_CYCLES−1.
- halt rises one cycle after the qualifying tohost write.

## Configuration
- PIPE_HAZARD_FWD_EN defined:
  - forwarding as described above;
  - only load-use hazards stall.
- PIPE_HAZARD_FWD_EN undefined:
  - fwd_sel_a/b are tied to 00;
  - any EX or WB match stalls until that writer has left WB (up to 2 cycles).

## Structure
- pipe_ctrl_pkg holds:
  - state_t;
  - FWD_RF=2'b00, FWD_EX=2'b01, FWD_WB=2'b10;
  - the scoreboard entry struct sb_entry_t.
- One sub-module, hazard_src_cmp, instantiated twice (rs1 and rs2). It produces the match_ex, match_wb and load_use flags and the fwd select for one source.

## Test plan
- EX holds ADD x5 (not a load); ID holds SUB reading x5 on rs1 → fwd_sel_a=01, pipe_en_id=1, no stall, stall_cnt unchanged.
- EX holds LW x7; ID reads x7 on rs2:
  - with FWD_EN: 1 stall cycle (pipe_en_id=0, bubble_ex=1), then fwd_sel_b=10 in the following cycle;
  - without FWD_EN: 2 stall cycles, then fwd=00.
- ID writes x0; the next instruction reads x0 → no match, fwd=00, no stall.
- ex_redirect pulse during a load-use stall, with FLUSH_CYCLES=2 → flush_id high for exactly 2 cycles, flush_cnt=2, back in RUN on the 3rd cycle.
- ex_tohost_we=1 with data=1, together with ex_redirect=1 → HALT the next cycle, halt=1, flush_id=0, counters frozen; rst_n low then high → halt=0, state RUN.
- Force 2^CNT_W+3 stall cycles → stall_cnt stays at all-ones.
